// File: rtl/clk_en_gen_pkg.sv
// Shared types and default parameter values for the clk_en_gen NCO clock-enable block.
package clk_en_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int ACC_W_DEF    = 24;
  localparam int LOCK_DLY_DEF = 16;

  // Settle counter is wide enough for the largest legal LOCK_DLY (65535).
  localparam int CNT_W = 16;

endpackage

// File: rtl/clk_en_gen_nco.sv
// One clock-enable channel: phase accumulator with registered carry-out as ce,
// a per-channel increment register and a synchronous phase clear.
module clk_en_gen_nco
  import clk_en_gen_pkg::*;
#(
  parameter int               ACC_W    = ACC_W_DEF,
  parameter logic [ACC_W-1:0] INC_INIT = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_we,
  input  logic [ACC_W-1:0] inc_new,
  output logic             ce
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // The increment written at an edge only affects additions from the next cycle on.
  always_ff @(posedge refclk) begin
    if (rst) begin
      acc <= '0;
      inc <= INC_INIT;
      ce  <= 1'b0;
    end else begin
      if (clr) begin
        acc <= '0;
        ce  <= 1'b0;
      end else begin
        acc <= sum[ACC_W-1:0];
        ce  <= sum[ACC_W];
      end
      if (inc_we) begin
        inc <= inc_new;
      end
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel NCO clock-enable generator with an update/settle/lock sequencer.
// Define CLK_EN_GEN_PHASE_ALIGN_EN to clear all accumulators when an update is applied.
//
// state  | meaning
// IDLE   | locked, cfg_ready=1, waiting for an increment update
// APPLY  | one cycle after an accepted update (optional phase clear)
// SETTLE | counting down LOCK_DLY cycles before relocking
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int                      NUM_CH   = 3,
  parameter int                      ACC_W    = ACC_W_DEF,
  parameter logic [NUM_CH*ACC_W-1:0] INC_INIT = {NUM_CH{ACC_W'(0)}},
  parameter int                      LOCK_DLY = LOCK_DLY_DEF
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(LOCK_DLY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             hs;
  logic             ch_ok;
  logic             align_clr;

  assign hs    = cfg_valid && cfg_ready;
  assign ch_ok = (32'(cfg_ch) < NUM_CH);

`ifdef CLK_EN_GEN_PHASE_ALIGN_EN
  assign align_clr = (state == ST_APPLY);
`else
  assign align_clr = 1'b0;
`endif

  // Out-of-range channel requests are consumed in IDLE without leaving it.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= ST_SETTLE;
      cnt       <= SETTLE_LOAD;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hs && ch_ok) begin
            state     <= ST_APPLY;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
          end
        end
        ST_APPLY: begin
          state <= ST_SETTLE;
          cnt   <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            state     <= ST_IDLE;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= ST_SETTLE;
          cnt       <= SETTLE_LOAD;
          locked    <= 1'b0;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic inc_we;

    assign inc_we = hs && ch_ok && (32'(cfg_ch) == g);

    clk_en_gen_nco #(
      .ACC_W    (ACC_W),
      .INC_INIT (INC_INIT[g*ACC_W +: ACC_W])
    ) u_nco (
      .refclk  (refclk),
      .rst     (rst),
      .clr     (align_clr),
      .inc_we  (inc_we),
      .inc_new (cfg_inc),
      .ce      (ce[g])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen: unwrapped-phase model compared every cycle plus directed literal checks.
module tb_clk_en_gen;

  localparam int NC = 3;
  localparam int W  = 4;
  localparam int LD = 4;
  localparam logic [NC*W-1:0] INIT = {4'd0, 4'd8, 4'd4};
  localparam int WIDE_CYC = 32768;
  localparam int WIDE_EXP = 15728;  // floor(32768 * 0x7AE148 / 2^24)

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [2:0]    cfg_ch = 3'd0;
  logic [W-1:0]  cfg_inc = '0;
  logic          cfg_ready;
  logic          locked;
  logic [NC-1:0] ce;

  logic          rst_w = 1'b1;
  logic          cfg_ready_w;
  logic          locked_w;
  logic [0:0]    ce_w;
  int            w_cnt = 0;
  bit            w_done = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 refclk = ~refclk;

  clk_en_gen #(.NUM_CH(NC), .ACC_W(W), .INC_INIT(INIT), .LOCK_DLY(LD)) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .ce(ce), .locked(locked)
  );

  clk_en_gen #(.NUM_CH(1), .ACC_W(24), .INC_INIT(24'h7AE148)) dut_w (
    .refclk(refclk), .rst(rst_w), .cfg_valid(1'b0), .cfg_ready(cfg_ready_w),
    .cfg_ch(3'd0), .cfg_inc(24'd0), .ce(ce_w), .locked(locked_w)
  );

  // Model: each channel's phase is kept unwrapped; a pulse is due whenever the
  // integer part (phase / 2^W) advances. m_rem counts cycles left before relock.
  longint unsigned m_phase [NC];
  logic [W-1:0]    m_inc [NC];
  logic [NC-1:0]   m_ce = '0;
  int              m_rem = LD;

  always @(posedge refclk) begin
    longint unsigned nxt;
    bit hs;
`ifdef CLK_EN_GEN_PHASE_ALIGN_EN
    bit apply_now;
    apply_now = (m_rem == LD + 1);
`endif
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        m_phase[i] = 0;
        m_inc[i]   = INIT[i*W +: W];
      end
      m_ce  = '0;
      m_rem = LD;
    end else begin
      hs = cfg_valid && (m_rem == 0);
      for (int i = 0; i < NC; i++) begin
        nxt        = m_phase[i] + 64'(m_inc[i]);
        m_ce[i]    = ((nxt >> W) != (m_phase[i] >> W));
        m_phase[i] = nxt;
`ifdef CLK_EN_GEN_PHASE_ALIGN_EN
        if (apply_now) begin
          m_phase[i] = 0;
          m_ce[i]    = 1'b0;
        end
`endif
      end
      if (hs && int'(cfg_ch) < NC) begin
        m_inc[int'(cfg_ch)] = cfg_inc;
        m_rem = LD + 1;
      end else if (m_rem > 0) begin
        m_rem = m_rem - 1;
      end
    end
  end

  always @(negedge refclk) begin
    logic exp_lock;
    exp_lock = (m_rem == 0);
    tests++;
    if (ce !== m_ce || locked !== exp_lock || cfg_ready !== exp_lock) begin
      fails++;
      $display("FAIL cycle_model t=%0t ce=%b exp=%b locked=%b exp=%b cfg_ready=%b exp=%b",
               $time, ce, m_ce, locked, exp_lock, cfg_ready, exp_lock);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic measure_gap(input int ch, output int gap);
    int n;
    gap = -1;
    n = 0;
    while (!ce[ch] && n < 40) begin step(1); n++; end
    if (!ce[ch]) return;
    n = 0;
    do begin step(1); n++; end while (!ce[ch] && n < 40);
    if (ce[ch]) gap = n;
  endtask

  task automatic write_cfg(input logic [2:0] ch, input logic [W-1:0] inc);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_inc   = inc;
    step(1);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!cfg_ready && n < 20) begin n++; step(1); end
  endtask

  initial begin
    repeat (2) @(posedge refclk);
    #1 rst_w = 1'b0;
    for (int k = 0; k < WIDE_CYC; k++) begin
      @(posedge refclk);
      #1;
      if (ce_w[0]) w_cnt++;
    end
    w_done = 1'b1;
  end

  initial begin
    int n, nl, gap, first0, first_lock, c1, c2;

    step(3);
    chk("reset_locked", locked, 0);
    chk("reset_ready", cfg_ready, 0);
    chk("reset_ce", ce, 0);
    rst = 1'b0;

    first0 = 0; first_lock = 0; c1 = 0; c2 = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      if (ce[0] && first0 == 0) first0 = k;
      if (locked && first_lock == 0) first_lock = k;
      if (ce[1]) c1++;
      if (ce[2]) c2++;
    end
    chk("first_ce0_edge", first0, 4);
    chk("first_lock_edge", first_lock, 4);
    chk("ce1_pulses_in_8", c1, 4);
    chk("ce2_pulses_in_8", c2, 0);

    write_cfg(3'd0, 4'd2);
    n = 0; nl = 0;
    while (!cfg_ready && n < 20) begin
      n++;
      if (!locked) nl++;
      step(1);
    end
    chk("ready_low_cycles", n, 5);
    chk("locked_low_cycles", nl, 5);
    chk("locked_after_update", locked, 1);
    measure_gap(0, gap);
    chk("ce0_period_inc2", gap, 8);
    measure_gap(1, gap);
    chk("ce1_period_unchanged", gap, 2);

    write_cfg(3'd5, 4'd15);
    chk("bad_ch5_ready", cfg_ready, 1);
    chk("bad_ch5_locked", locked, 1);
    write_cfg(3'd3, 4'd15);
    chk("bad_ch3_ready", cfg_ready, 1);
    measure_gap(0, gap);
    chk("ce0_period_after_bad", gap, 8);

    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_inc = 4'd4;
    step(3);
    cfg_valid = 1'b0;
    wait_ready(n);
    chk("held_valid_relock", cfg_ready, 1);
    measure_gap(1, gap);
    chk("ce1_period_inc4", gap, 4);

    write_cfg(3'd2, 4'd2);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n = 0;
    while (!locked && n < 20) begin n++; step(1); end
    chk("relock_after_rst", n, 4);
    c2 = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (ce[2]) c2++;
    end
    chk("ce2_after_rst", c2, 0);
    measure_gap(0, gap);
    chk("ce0_period_init", gap, 4);
    measure_gap(1, gap);
    chk("ce1_period_init", gap, 2);

    n = 0;
    while (!w_done && n < 40000) begin n++; step(1); end
    chk("wide_done", w_done, 1);
    tests++;
    if (w_cnt < WIDE_EXP - 1 || w_cnt > WIDE_EXP + 1) begin
      fails++;
      $display("FAIL wide_ce_count: got %0d expected %0d +/-1", w_cnt, WIDE_EXP);
    end
    chk("wide_locked", locked_w, 1);
    chk("wide_ready", cfg_ready_w, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of clock-enable channels (legal 1..8).
REQ-002 SHALL have parameter ACC_W, default 24, phase-accumulator and increment width (legal 4..32).
REQ-003 SHALL have parameter INC_INIT, default {NUM_CH{ACC_W'(0)}}, packed per-channel reset increments (channel 0 in the LSBs).
REQ-004 SHALL have parameter LOCK_DLY, default 16, settle cycles before locked asserts (legal 1..65535).
REQ-005 SHALL have port refclk  in  1  sole clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port cfg_valid  in  1  increment-update request.
REQ-008 SHALL have port cfg_ready  out  1  update can be accepted.
REQ-009 SHALL have port cfg_ch  in  3  target channel index.
REQ-010 SHALL have port cfg_inc  in  ACC_W  new increment; f_ce = f_refclk * cfg_inc / 2^ACC_W.
REQ-011 SHALL have port ce  out  NUM_CH  per-channel one-cycle clock-enable pulses.
REQ-012 SHALL have port locked  out  1  all channels running at their programmed rates.

Function
REQ-013 Each channel SHALL register acc <= acc + inc (mod 2^ACC_W) every cycle, and ce[i] <= carry-out of that same addition, so ce is registered with no combinational path from inputs.
REQ-014 inc = 0 SHALL produce no ce pulses; inc >= 2^(ACC_W-1) SHALL produce ce high in at least every second cycle; no other clamping.
REQ-015 Control FSM states SHALL be IDLE, APPLY, SETTLE.
REQ-016 In IDLE, cfg_ready SHALL be 1; cfg_valid && cfg_ready is a handshake; all other states SHALL drive cfg_ready = 0.
REQ-017 On a handshake with cfg_ch < NUM_CH, inc[cfg_ch] SHALL take cfg_inc at that edge, and the FSM SHALL go to APPLY.
REQ-018 On a handshake with cfg_ch >= NUM_CH, the request SHALL be consumed with no state change and the FSM SHALL stay in IDLE with locked unchanged.
REQ-019 APPLY SHALL last exactly one cycle, with locked = 0 from that cycle onward, and SHALL load the settle counter with LOCK_DLY-1 before moving to SETTLE.
REQ-020 SETTLE SHALL decrement the counter each cycle and return to IDLE at zero; locked and cfg_ready SHALL go to 1 in the first IDLE cycle.
REQ-021 ce SHALL keep running on all channels in every FSM state; unaffected channels SHALL never skip or duplicate a pulse because of an update.
REQ-022 cfg_valid held high SHALL produce at most one accepted update per IDLE visit.

Reset
REQ-023 While rst = 1: every acc = 0, inc = INC_INIT, ce = 0, the FSM enters SETTLE with counter = LOCK_DLY-1, locked = 0, cfg_ready = 0.
REQ-024 After rst deasserts: locked = 1 after exactly LOCK_DLY cycles. rst asserted mid-SETTLE or mid-APPLY SHALL restart the full sequence in REQ-023 and discard any applied increment in favour of INC_INIT.

Configuration
REQ-025 With macro CLK_EN_GEN_PHASE_ALIGN_EN defined, APPLY SHALL clear every channel acc to 0 in the same cycle, phase-aligning all channels; ce SHALL be 0 in the cycle after APPLY.
REQ-026 Without CLK_EN_GEN_PHASE_ALIGN_EN, APPLY SHALL not touch any acc; only inc[cfg_ch] changes.

Structure
REQ-027 Package clk_en_gen_pkg SHALL hold the FSM state enum and the default values of ACC_W and LOCK_DLY.
REQ-028 Each channel SHALL be an instance of sub-module clk_en_gen_nco (acc, inc register, carry -> ce, sync clear), generated NUM_CH times.

Verification (NUM_CH=3, ACC_W=4, LOCK_DLY=4 unless stated)
REQ-029 INC_INIT {0,8,4}, release rst -> ce[0] pulses every 4 cycles, first pulse on the 4th edge after release; ce[1] every 2 cycles; ce[2] never; locked = 1 on the 4th cycle.
REQ-030 In IDLE, write ch 0 inc = 2 -> cfg_ready = 0 for 5 cycles, locked = 0 for 5 cycles, then ce[0] has period 8; ce[1] cadence is unbroken (feature off).
REQ-031 Same as REQ-030 with CLK_EN_GEN_PHASE_ALIGN_EN -> all acc = 0 after APPLY, and ce[0] and ce[1] first coincide 8 cycles later.
REQ-032 cfg_valid high with cfg_ch = 5 -> accepted in one cycle, no inc change, locked stays 1, cfg_ready stays 1.
REQ-033 rst pulsed during SETTLE after a write of inc = 2 -> inc returns to INC_INIT, locked = 1 exactly 4 cycles after rst drops.
REQ-034 ACC_W=24, inc = 0x7AE148 (about 0.48 of the 2^24 full scale) for 2^20 cycles -> ce count within +/-1 of 503316.
